// File: rtl/uart_dev.sv
// Memory-mapped 8N1 UART: DATA/STATUS/CTRL registers, TX and RX FSMs, level IRQ on rx_valid & ien.
// RX sees rxd 2 cycles late through a synchroniser; UART_LOOPBACK_EN adds CTRL[1] to feed txd into RX.
module uart_dev #(
    parameter logic [15:0] DIV_RST = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic        RE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    input  logic        rxd,
    output logic        txd
);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic [15:0] r_div;
    logic        r_ien;
    logic        w_loop_bit;

    state_t      r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [15:0] r_tx_div;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_txd;

    state_t      r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [15:0] r_rx_div;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_ovr;
    logic        r_ferr;

    logic        w_wr_data;
    logic        w_wr_ctrl;
    logic        w_rd_data;
    logic        w_rd_stat;
    logic        w_tx_busy;
    logic        w_rx_src;
    logic [15:0] w_din_div;
    logic        w_unused_bits;

    assign w_wr_data = WE && (Addr[1:0] == 2'd0);
    assign w_wr_ctrl = WE && (Addr[1:0] == 2'd2);
    assign w_rd_data = RE && (Addr[1:0] == 2'd0);
    assign w_rd_stat = RE && (Addr[1:0] == 2'd1);
    assign w_tx_busy = (r_tx_state != ST_IDLE);
    assign w_din_div = (Din[31:16] < 16'd2) ? 16'd2 : Din[31:16];
    assign w_unused_bits = &{1'b0, Addr[29:2], Din[15:1]};

`ifdef UART_LOOPBACK_EN
    logic r_loop;
    assign w_loop_bit = r_loop;
    assign w_rx_src   = r_loop ? r_txd : rxd;
`else
    assign w_loop_bit = 1'b0;
    assign w_rx_src   = rxd;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= DIV_RST;
            r_ien <= 1'b0;
`ifdef UART_LOOPBACK_EN
            r_loop <= 1'b0;
`endif
        end else if (w_wr_ctrl) begin
            r_div <= w_din_div;
            r_ien <= Din[0];
`ifdef UART_LOOPBACK_EN
            r_loop <= Din[1];
`endif
        end
    end

    // Transmitter: txd is a flop so it changes exactly on bit boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_div   <= DIV_RST;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_wr_data) begin
                        r_tx_state <= ST_START;
                        r_tx_shift <= Din[7:0];
                        r_tx_div   <= r_div;
                        r_tx_cnt   <= 16'd0;
                        r_tx_bit   <= 3'd0;
                        r_txd      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (r_tx_cnt == r_tx_div - 16'd1) begin
                        r_tx_state <= ST_DATA;
                        r_tx_cnt   <= 16'd0;
                        r_txd      <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (r_tx_cnt == r_tx_div - 16'd1) begin
                        r_tx_cnt <= 16'd0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= ST_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_tx_cnt == r_tx_div - 16'd1) begin
                        r_tx_state <= ST_IDLE;
                        r_tx_cnt   <= 16'd0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    // Receiver. Pops and status clears come first so a completion on the same edge wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_div   <= DIV_RST;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_rx_s1 <= w_rx_src;
            r_rx_s2 <= r_rx_s1;
            if (w_rd_data) r_rx_valid <= 1'b0;
            if (w_rd_stat) begin
                r_ovr  <= 1'b0;
                r_ferr <= 1'b0;
            end
            case (r_rx_state)
                ST_IDLE: begin
                    if (r_rx_s2 && !r_rx_s1) begin
                        r_rx_state <= ST_START;
                        r_rx_cnt   <= 16'd0;
                        r_rx_div   <= r_div;
                    end
                end
                ST_START: begin
                    if (r_rx_cnt == (r_rx_div >> 1) - 16'd1) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (r_rx_cnt == r_rx_div - 16'd1) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= ST_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_rx_cnt == r_rx_div - 16'd1) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_state <= ST_IDLE;
                        if (!r_rx_s2) begin
                            r_ferr <= 1'b1;
                        end else if (r_rx_valid && !w_rd_data) begin
                            r_ovr <= 1'b1;
                        end else begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[1:0])
            2'd0:    Dout = {24'd0, r_rx_data};
            2'd1:    Dout = {27'd0, r_ferr, r_ovr, r_rx_valid, w_tx_busy, 1'b0};
            2'd2:    Dout = {r_div, 14'd0, w_loop_bit, r_ien};
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = r_rx_valid & r_ien;
    assign txd = r_txd;

endmodule

// File: tb/tb_uart_dev.sv
// Directed bench for uart_dev: register map, TX/RX framing, overrun, framing error, reset abort.
module tb_uart_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic        RE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        rxd;
    logic        txd;

    int n_checks = 0;
    int n_errors = 0;

    uart_dev #(.DIV_RST(16'd16)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .RE(RE), .Din(Din),
        .Dout(Dout), .IRQ(IRQ), .rxd(rxd), .txd(txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = {28'd0, a}; Din = d; WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        Addr = {28'd0, a}; RE = 1'b1;
        #1 d = Dout;
        @(negedge clk);
        RE = 1'b0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'd0, a};
        #1 d = Dout;
    endtask

    // Drives one 16-cycle-per-bit frame on rxd starting at the current negedge.
    task automatic send_rx(input logic [7:0] b, input logic stopb);
        for (int k = 0; k < 160; k++) begin
            rxd = (k < 16) ? 1'b0 : (k < 144) ? b[(k - 16) / 16] : stopb;
            @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k - 1];
        return 1'b1;
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b0; WE = 1'b0; RE = 1'b0; Addr = '0; Din = '0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (txd !== 1'b1) begin n_errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_checks++; if (IRQ !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL reset_status: got %h expected 00000000", d); end
        peek(2'd2, d);
        n_checks++; if (d !== 32'h0010_0000) begin n_errors++; $display("FAIL reset_ctrl: got %h expected 00100000", d); end
        peek(2'd0, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 00000000", d); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_regs;
        logic [31:0] d;
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        peek(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL reserved_read: got %h expected 00000000", d); end
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL status_wr_ignored: got %h expected 00000000", d); end
        peek(2'd2, d);
        n_checks++; if (d !== 32'h0010_0000) begin n_errors++; $display("FAIL ctrl_untouched: got %h expected 00100000", d); end
    endtask

    task automatic test_tx;
        wr(2'd0, 32'h0000_00A5);
        Addr = 30'd1;
        #1;
        for (int i = 0; i < 160; i++) begin
            n_checks++; if (txd !== exp_tx(8'hA5, i / 16)) begin n_errors++; $display("FAIL tx_bit cyc %0d: got %b expected %b", i, txd, exp_tx(8'hA5, i / 16)); end
            n_checks++; if (Dout[1] !== 1'b1) begin n_errors++; $display("FAIL tx_busy cyc %0d: got %b expected 1", i, Dout[1]); end
            @(negedge clk);
            #1;
        end
        n_checks++; if (txd !== 1'b1) begin n_errors++; $display("FAIL tx_idle_txd: got %b expected 1", txd); end
        n_checks++; if (Dout[1] !== 1'b0) begin n_errors++; $display("FAIL tx_done_busy: got %b expected 0", Dout[1]); end
    endtask

    task automatic test_rx;
        logic [31:0] d;
        wr(2'd2, 32'h0010_0001);
        send_rx(8'h3C, 1'b1);
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0000_0004) begin n_errors++; $display("FAIL rx_status: got %h expected 00000004", d); end
        n_checks++; if (IRQ !== 1'b1) begin n_errors++; $display("FAIL rx_irq_set: got %b expected 1", IRQ); end
        rd(2'd0, d);
        n_checks++; if (d !== 32'h0000_003C) begin n_errors++; $display("FAIL rx_data: got %h expected 0000003c", d); end
        n_checks++; if (IRQ !== 1'b0) begin n_errors++; $display("FAIL rx_irq_clr: got %b expected 0", IRQ); end
    endtask

    task automatic test_glitch_ferr;
        logic [31:0] d;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL glitch_status: got %h expected 00000000", d); end
        @(negedge clk);
        send_rx(8'h55, 1'b0);
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0000_0010) begin n_errors++; $display("FAIL ferr_status: got %h expected 00000010", d); end
        rd(2'd1, d);
        n_checks++; if (d !== 32'h0000_0010) begin n_errors++; $display("FAIL ferr_read: got %h expected 00000010", d); end
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL ferr_cleared: got %h expected 00000000", d); end
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        @(negedge clk);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0000_000C) begin n_errors++; $display("FAIL ovr_status: got %h expected 0000000c", d); end
        rd(2'd0, d);
        n_checks++; if (d !== 32'h0000_0011) begin n_errors++; $display("FAIL ovr_keep_old: got %h expected 00000011", d); end
        rd(2'd1, d);
        n_checks++; if (d !== 32'h0000_0008) begin n_errors++; $display("FAIL ovr_read: got %h expected 00000008", d); end
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL ovr_cleared: got %h expected 00000000", d); end
    endtask

    // Pop on the exact edge of the stop sample: new byte must load without overrun.
    task automatic test_same_edge;
        logic [31:0] d;
        logic [7:0]  b;
        b = 8'h22;
        @(negedge clk);
        send_rx(8'h11, 1'b1);
        for (int k = 0; k < 160; k++) begin
            rxd = (k < 16) ? 1'b0 : (k < 144) ? b[(k - 16) / 16] : 1'b1;
            if (k == 153) begin
                Addr = 30'd0; RE = 1'b1;
                #1;
                n_checks++; if (Dout !== 32'h0000_0011) begin n_errors++; $display("FAIL same_edge_old: got %h expected 00000011", Dout); end
            end
            if (k == 154) RE = 1'b0;
            @(negedge clk);
        end
        rxd = 1'b1;
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0000_0004) begin n_errors++; $display("FAIL same_edge_status: got %h expected 00000004", d); end
        rd(2'd0, d);
        n_checks++; if (d !== 32'h0000_0022) begin n_errors++; $display("FAIL same_edge_data: got %h expected 00000022", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        wr(2'd2, 32'h0010_0000);
        wr(2'd0, 32'h0000_0081);
        wr(2'd0, 32'h0000_00FF);
        wr(2'd2, 32'h0008_0000);
        Addr = 30'd1;
        #1;
        for (int i = 4; i < 160; i++) begin
            n_checks++; if (txd !== exp_tx(8'h81, i / 16)) begin n_errors++; $display("FAIL b2b_bit cyc %0d: got %b expected %b", i, txd, exp_tx(8'h81, i / 16)); end
            @(negedge clk);
            #1;
        end
        n_checks++; if (Dout[1] !== 1'b0) begin n_errors++; $display("FAIL b2b_idle: got %b expected 0", Dout[1]); end
        wr(2'd0, 32'h0000_00F0);
        Addr = 30'd1;
        #1;
        for (int i = 0; i < 80; i++) begin
            n_checks++; if (txd !== exp_tx(8'hF0, i / 8)) begin n_errors++; $display("FAIL div8_bit cyc %0d: got %b expected %b", i, txd, exp_tx(8'hF0, i / 8)); end
            @(negedge clk);
            #1;
        end
        peek(2'd1, d);
        n_checks++; if (d[1] !== 1'b0) begin n_errors++; $display("FAIL div8_idle: got %b expected 0", d[1]); end
    endtask

    task automatic test_div_min;
        logic [31:0] d;
        wr(2'd2, 32'h0001_0000);
        peek(2'd2, d);
        n_checks++; if (d !== 32'h0002_0000) begin n_errors++; $display("FAIL div1_clamp: got %h expected 00020000", d); end
        wr(2'd2, 32'h0000_0000);
        peek(2'd2, d);
        n_checks++; if (d !== 32'h0002_0000) begin n_errors++; $display("FAIL div0_clamp: got %h expected 00020000", d); end
        wr(2'd0, 32'h0000_0001);
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (txd !== exp_tx(8'h01, i / 2)) begin n_errors++; $display("FAIL div2_bit cyc %0d: got %b expected %b", i, txd, exp_tx(8'h01, i / 2)); end
            @(negedge clk);
        end
        peek(2'd1, d);
        n_checks++; if (d[1] !== 1'b0) begin n_errors++; $display("FAIL div2_idle: got %b expected 0", d[1]); end
    endtask

    task automatic test_reset_mid_tx;
        logic [31:0] d;
        wr(2'd2, 32'h0010_0001);
        wr(2'd0, 32'h0000_00A5);
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (txd !== 1'b1) begin n_errors++; $display("FAIL abort_txd: got %b expected 1", txd); end
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL abort_status: got %h expected 00000000", d); end
        peek(2'd2, d);
        n_checks++; if (d !== 32'h0010_0000) begin n_errors++; $display("FAIL abort_ctrl: got %h expected 00100000", d); end
        @(negedge clk);
        reset = 1'b1;
        wr(2'd0, 32'h0000_005A);
        peek(2'd1, d);
        n_checks++; if (txd !== 1'b0 || d[1] !== 1'b1) begin n_errors++; $display("FAIL restart_tx: got txd=%b busy=%b expected txd=0 busy=1", txd, d[1]); end
        repeat (170) @(negedge clk);
    endtask

    task automatic test_ctrl_loop;
        logic [31:0] d;
        wr(2'd2, 32'h0010_0003);
        peek(2'd2, d);
`ifdef UART_LOOPBACK_EN
        n_checks++; if (d !== 32'h0010_0003) begin n_errors++; $display("FAIL loop_ctrl: got %h expected 00100003", d); end
        wr(2'd0, 32'h0000_0096);
        repeat (170) @(negedge clk);
        peek(2'd0, d);
        n_checks++; if (d !== 32'h0000_0096) begin n_errors++; $display("FAIL loop_data: got %h expected 00000096", d); end
        n_checks++; if (IRQ !== 1'b1) begin n_errors++; $display("FAIL loop_irq: got %b expected 1", IRQ); end
`else
        n_checks++; if (d !== 32'h0010_0001) begin n_errors++; $display("FAIL noloop_ctrl: got %h expected 00100001", d); end
        wr(2'd0, 32'h0000_0096);
        repeat (170) @(negedge clk);
        peek(2'd1, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL noloop_status: got %h expected 00000000", d); end
        n_checks++; if (IRQ !== 1'b0) begin n_errors++; $display("FAIL noloop_irq: got %b expected 0", IRQ); end
`endif
    endtask

    initial begin
        test_reset();
        test_regs();
        test_tx();
        test_rx();
        test_glitch_ferr();
        test_overrun();
        test_same_edge();
        test_back_to_back();
        test_div_min();
        test_reset_mid_tx();
        test_ctrl_loop();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
